// File: rtl/booth_pkg.sv
// booth_pkg: shared state type, Booth pair codes and counter width helper for booth_mult_seq
package booth_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [1:0] BOOTH_NOP = 2'b00;
    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

    function automatic int CNT_W(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/booth_addsub.sv
// booth_addsub: W-bit combinational adder/subtractor, sub=1 gives x-y
module booth_addsub #(
    parameter int W = 5
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         sub,
    output logic [W-1:0] s
);

    assign s = sub ? x - y : x + y;

endmodule

// File: rtl/booth_mult_seq.sv
// booth_mult_seq: sequential radix-2 Booth multiplier with start/done handshake.
// Define BOOTH_ZERO_SKIP_EN to finish immediately when either operand is zero.
module booth_mult_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   prod
);

    localparam int CW = CNT_W(WIDTH);

    state_t           state, state_nx;
    logic [WIDTH:0]   m, hq, sum, hq_new;
    logic [WIDTH-1:0] q;
    logic             q_1;
    logic [CW-1:0]    cnt;
    logic [1:0]       pair;
    logic             accept, zero, last;

    assign pair   = {q[0], q_1};
    assign accept = start && (state == IDLE || state == DONE);
    assign last   = cnt == CW'(1);

`ifdef BOOTH_ZERO_SKIP_EN
    assign zero = (a == '0) || (b == '0);
`else
    assign zero = 1'b0;
`endif

    booth_addsub #(.W(WIDTH + 1)) u_addsub (
        .x   (hq),
        .y   (m),
        .sub (pair == BOOTH_SUB),
        .s   (sum)
    );

    assign hq_new = (pair == BOOTH_ADD || pair == BOOTH_SUB) ? sum : hq;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = IDLE;
        if (accept)              state_nx = zero ? DONE : CALC;
        else if (state == CALC)  state_nx = last ? DONE : CALC;
        busy = state == CALC;
        done = state == DONE;
    end

    // The shifted product is {hq_new, q} >>> 1; its low 2*WIDTH bits drop only q[0].
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m    <= '0;
            hq   <= '0;
            q    <= '0;
            q_1  <= 1'b0;
            cnt  <= '0;
            prod <= '0;
        end else if (accept) begin
            m    <= {a[WIDTH-1], a};
            q    <= b;
            hq   <= '0;
            q_1  <= 1'b0;
            cnt  <= CW'(WIDTH);
            if (zero) prod <= '0;
        end else if (state == CALC) begin
            hq   <= {hq_new[WIDTH], hq_new[WIDTH:1]};
            q    <= {hq_new[0], q[WIDTH-1:1]};
            q_1  <= q[0];
            cnt  <= cnt - 1'b1;
            if (last) prod <= {hq_new, q[WIDTH-1:1]};
        end
    end

endmodule

// File: tb/tb_booth_mult_seq.sv
// tb_booth_mult_seq: table, corner-sequence and random checks of booth_mult_seq at WIDTH 4 and 8
module tb_booth_mult_seq;

`ifdef BOOTH_ZERO_SKIP_EN
    localparam bit ZS = 1'b1;
`else
    localparam bit ZS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start4 = 1'b0, start8 = 1'b0;
    logic [3:0]  a4 = '0, b4 = '0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy4, done4, busy8, done8;
    logic [7:0]  prod4;
    logic [15:0] prod8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    booth_mult_seq #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .prod(prod4)
    );

    booth_mult_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .prod(prod8)
    );

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] p;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] model(input int w, input logic [7:0] av, input logic [7:0] bv);
        int r;
        if (w == 4) begin
            r = int'($signed(av[3:0])) * int'($signed(bv[3:0]));
            return {8'h00, r[7:0]};
        end
        r = int'($signed(av)) * int'($signed(bv));
        return r[15:0];
    endfunction

    function automatic int exp_lat(input int w, input logic [7:0] av, input logic [7:0] bv);
        logic z;
        z = (w == 4) ? (av[3:0] == 4'h0 || bv[3:0] == 4'h0) : (av == 8'h00 || bv == 8'h00);
        return (ZS && z) ? 1 : w + 1;
    endfunction

    // lat = index of the negedge after the accepting edge at which done is first seen
    task automatic run_op(input int w, input logic [7:0] av, input logic [7:0] bv,
                          output logic [15:0] p, output int lat, output int bz);
        @(negedge clk);
        if (w == 4) begin a4 = av[3:0]; b4 = bv[3:0]; start4 = 1'b1; end
        else begin a8 = av; b8 = bv; start8 = 1'b1; end
        lat = 0; bz = 0; p = '0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            start4 = 1'b0; start8 = 1'b0;
            if (w == 4 ? busy4 : busy8) bz++;
            if (w == 4 ? done4 : done8) begin
                lat = n;
                p = (w == 4) ? {8'h00, prod4} : prod8;
                break;
            end
        end
        chk("done_seen", 64'(lat != 0), 64'd1);
    endtask

    initial begin
        vec_t       vt[8];
        logic [15:0] p;
        logic [7:0]  ra, rb, prev;
        int          lat, bz, cnt;

        vt[0] = '{4'h3, 4'hE, 8'hFA};
        vt[1] = '{4'h8, 4'h8, 8'h40};
        vt[2] = '{4'h8, 4'h7, 8'hC8};
        vt[3] = '{4'h7, 4'h7, 8'h31};
        vt[4] = '{4'hF, 4'hF, 8'h01};
        vt[5] = '{4'h7, 4'h8, 8'hC8};
        vt[6] = '{4'h0, 4'h5, 8'h00};
        vt[7] = '{4'h1, 4'h8, 8'hF8};

        #3;
        chk("rst_busy", 64'(busy4), 64'd0);
        chk("rst_done", 64'(done4), 64'd0);
        chk("rst_prod", 64'(prod4), 64'd0);
        chk("rst_prod8", 64'(prod8), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_op(4, {4'h0, vt[i].a}, {4'h0, vt[i].b}, p, lat, bz);
            chk($sformatf("tbl_prod[%0d]", i), 64'(p), 64'(vt[i].p));
            chk($sformatf("tbl_lat[%0d]", i), 64'(lat), 64'(exp_lat(4, {4'h0, vt[i].a}, {4'h0, vt[i].b})));
            chk($sformatf("tbl_busy[%0d]", i), 64'(bz), 64'(exp_lat(4, {4'h0, vt[i].a}, {4'h0, vt[i].b}) - 1));
        end

        // back-to-back with start held through DONE
        @(negedge clk);
        a4 = 4'h8; b4 = 4'h8; start4 = 1'b1;
        cnt = 0;
        for (int n = 1; n <= 20 && cnt == 0; n++) begin
            @(negedge clk);
            if (done4) cnt = n;
        end
        chk("b2b_first_lat", 64'(cnt), 64'd5);
        chk("b2b_first_prod", 64'(prod4), 64'h40);
        a4 = 4'h8; b4 = 4'h7;
        @(negedge clk);
        start4 = 1'b0;
        chk("b2b_restart_busy", 64'(busy4), 64'd1);
        chk("b2b_restart_done", 64'(done4), 64'd0);
        chk("b2b_prod_hold", 64'(prod4), 64'h40);
        cnt = 0;
        for (int n = 2; n <= 20 && cnt == 0; n++) begin
            @(negedge clk);
            if (done4) cnt = n;
        end
        chk("b2b_spacing", 64'(cnt), 64'd5);
        chk("b2b_second_prod", 64'(prod4), 64'hC8);

        // start pulses during CALC are ignored
        prev = prod4;
        @(negedge clk);
        a4 = 4'h3; b4 = 4'hE; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        chk("ign_prod_hold", 64'(prod4), 64'(prev));
        @(negedge clk);
        a4 = 4'h7; b4 = 4'h7; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0; a4 = 4'h5; b4 = 4'h5;
        cnt = 0; p = '0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (done4) begin cnt++; p = {8'h00, prod4}; end
        end
        chk("ign_done_pulses", 64'(cnt), 64'd1);
        chk("ign_prod", 64'(p), 64'hFA);
        chk("ign_prod_held", 64'(prod4), 64'hFA);
        chk("ign_idle_busy", 64'(busy4), 64'd0);

        // asynchronous reset mid-CALC
        @(negedge clk);
        a4 = 4'h5; b4 = 4'h3; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_busy", 64'(busy4), 64'd0);
        chk("arst_done", 64'(done4), 64'd0);
        chk("arst_prod", 64'(prod4), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (done4 || busy4) cnt++;
        end
        chk("arst_no_done", 64'(cnt), 64'd0);
        run_op(4, 8'h05, 8'h03, p, lat, bz);
        chk("arst_after_prod", 64'(p), 64'h0F);
        chk("arst_after_lat", 64'(lat), 64'd5);

        // zero operand timing
        run_op(4, 8'h00, 8'h05, p, lat, bz);
        chk("zero_prod", 64'(p), 64'h00);
        chk("zero_lat", 64'(lat), ZS ? 64'd1 : 64'd5);
        chk("zero_busy", 64'(bz), ZS ? 64'd0 : 64'd4);

        // WIDTH=8 random sweep against the signed reference
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            if (i == 0) begin ra = 8'h80; rb = 8'h80; end
            if (i == 1) begin ra = 8'h80; rb = 8'h7F; end
            run_op(8, ra, rb, p, lat, bz);
            chk($sformatf("rnd_prod a=%0h b=%0h", ra, rb), 64'(p), 64'(model(8, ra, rb)));
            chk($sformatf("rnd_lat a=%0h b=%0h", ra, rb), 64'(lat), 64'(exp_lat(8, ra, rb)));
        end

        // WIDTH=4 random against the same reference
        for (int i = 0; i < 100; i++) begin
            ra = 8'($urandom_range(0, 15));
            rb = 8'($urandom_range(0, 15));
            run_op(4, ra, rb, p, lat, bz);
            chk($sformatf("rnd4_prod a=%0h b=%0h", ra, rb), 64'(p), 64'(model(4, ra, rb)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
